// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared constants and types for the PDM microphone PCM path.
//   PCM_WIDTH      : default PCM sample width (two's complement)
//   PCM_DEPTH_LOG2 : default log2 of the PCM FIFO depth
//   PCM_DC_SHIFT   : default leaky-integrator shift of the DC blocker
//   PCM_MAX/MIN    : 16-bit saturation limits
//   pcm_t          : signed 16-bit PCM sample
// -----------------------------------------------------------------------------
package pdm_pkg;

  localparam int PCM_WIDTH      = 16;
  localparam int PCM_DEPTH_LOG2 = 3;
  localparam int PCM_DC_SHIFT   = 6;

  localparam logic [15:0] PCM_MAX = 16'h7FFF;
  localparam logic [15:0] PCM_MIN = 16'h8000;

  typedef logic signed [15:0] pcm_t;

endpackage : pdm_pkg

// File: rtl/pdm_dc_block.sv
// -----------------------------------------------------------------------------
// pdm_dc_block
// One-stage DC blocker placed in front of the PCM FIFO when the design is
// built with PDM_PCM_DCBLOCK_EN. A leaky integrator tracks the DC estimate
// (est = acc >>> DC_SHIFT); each accepted sample produces the saturated
// difference in - est one cycle later.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   accept_i     : input sample strobe (already qualified by enable)
//   pcm_i        : input sample
//   flush_i      : drops an output sample still pending in this stage
//   valid_o      : registered output strobe (FIFO push event)
//   pcm_o        : registered, saturated output sample
// -----------------------------------------------------------------------------
module pdm_dc_block
  import pdm_pkg::*;
#(
  parameter int WIDTH    = PCM_WIDTH,
  parameter int DC_SHIFT = PCM_DC_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic [WIDTH-1:0] pcm_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pcm_o
);

  localparam int ACC_W = WIDTH + DC_SHIFT;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] est;
  logic signed [ACC_W:0]   diff;   // one guard bit so in - est never wraps
  logic [WIDTH-1:0]        y_sat;
  logic                    valid_q;
  logic [WIDTH-1:0]        pcm_q;

  always_comb begin
    in_ext = {{DC_SHIFT{pcm_i[WIDTH-1]}}, pcm_i};
    est    = acc_q >>> DC_SHIFT;
    diff   = {in_ext[ACC_W-1], in_ext} - {est[ACC_W-1], est};
    acc_d  = acc_q + in_ext - est;
    // The difference fits in WIDTH bits only when every bit above the WIDTH
    // sign bit repeats it; otherwise clamp toward the sign of diff.
    if (diff[ACC_W:WIDTH-1] == {(ACC_W-WIDTH+2){diff[WIDTH-1]}})
      y_sat = diff[WIDTH-1:0];
    else if (diff[ACC_W])
      y_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      y_sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
      pcm_q   <= '0;
    end else begin
      valid_q <= accept_i && !flush_i;
      if (accept_i) begin
        acc_q <= acc_d;
        pcm_q <= y_sat;
      end
    end
  end

  assign valid_o = valid_q;
  assign pcm_o   = pcm_q;

endmodule : pdm_dc_block

// File: rtl/pdm_pcm_fifo.sv
// -----------------------------------------------------------------------------
// pdm_pcm_fifo
// First-word fall-through FIFO for PCM samples from the CIC3 decimator, with
// fill level, level-threshold interrupt and sticky overflow flag.
// Build option: define PDM_PCM_DCBLOCK_EN to insert pdm_dc_block in front of
// the FIFO (adds one cycle of push latency).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : gates in_valid; reads keep working when low
//   in_pcm     : sample from the decimator, in_valid its one-cycle strobe
//   rd_en      : pop the head sample (ignored when empty)
//   rd_data    : head sample, 0 when empty
//   level      : stored sample count 0..DEPTH; empty / full decode it
//   threshold  : interrupt level (0 disables); irq is registered
//   overflow   : sticky drop flag, cleared by ovf_clear
//   flush      : empties the FIFO, beats push and pop
// -----------------------------------------------------------------------------
module pdm_pcm_fifo
  import pdm_pkg::*;
#(
  parameter int WIDTH      = PCM_WIDTH,
  parameter int DEPTH_LOG2 = PCM_DEPTH_LOG2,
  parameter int DC_SHIFT   = PCM_DC_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      in_pcm,
  input  logic                  in_valid,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  input  logic [DEPTH_LOG2:0]   threshold,
  output logic                  irq,
  output logic                  overflow,
  input  logic                  ovf_clear,
  input  logic                  flush
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic             push_valid;
  logic [WIDTH-1:0] push_data;

`ifdef PDM_PCM_DCBLOCK_EN
  pdm_dc_block #(
    .WIDTH    (WIDTH),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk      (clk),
    .rst      (rst),
    .accept_i (in_valid && enable),
    .pcm_i    (in_pcm),
    .flush_i  (flush),
    .valid_o  (push_valid),
    .pcm_o    (push_data)
  );
`else
  assign push_valid = in_valid && enable;
  assign push_data  = in_pcm;
`endif

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;
  logic                  is_empty, is_full;
  logic                  pop, push_ok, drop;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == DEPTH_LVL);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    pop      = rd_en && !is_empty;
    // A push into a full FIFO still succeeds when the same cycle pops.
    push_ok  = push_valid && (!is_full || pop);
    drop     = push_valid && is_full && !pop && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    end
    // A drop in the same cycle wins over ovf_clear.
    ovf_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : ovf_q);
    // Registered from next-state level so irq tracks level without a lag.
    irq_d = (threshold != '0) && (level_d >= threshold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are never visible
  // because rd_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign rd_data  = is_empty ? '0 : mem[rd_ptr_q];
  assign level    = level_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign irq      = irq_q;
  assign overflow = ovf_q;

endmodule : pdm_pcm_fifo

// File: tb/tb_pdm_pcm_fifo.sv
// -----------------------------------------------------------------------------
// tb_pdm_pcm_fifo
// Self-checking bench for pdm_pcm_fifo. A queue-based reference model follows
// the FIFO rules; with PDM_PCM_DCBLOCK_EN defined a DC-blocker scenario runs
// against an integer model of the leaky integrator instead.
// -----------------------------------------------------------------------------
module tb_pdm_pcm_fifo;
  import pdm_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] in_pcm = '0;
  logic        in_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        empty, full;
  logic [3:0]  threshold = '0;
  logic        irq, overflow;
  logic        ovf_clear = 1'b0;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_irq = 1'b0;

  pdm_pcm_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_pcm    (in_pcm),
    .in_valid  (in_valid),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .threshold (threshold),
    .irq       (irq),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_head();
    return (q.size() > 0) ? q[0] : 16'h0000;
  endfunction

  // Apply one cycle of stimulus, step the model, and leave outputs settled
  // (#1 after the edge) for the caller to compare.
  task automatic drive(input bit v, input logic [15:0] d, input bit rd,
                       input bit fl = 1'b0, input bit oc = 1'b0);
    bit push, pop, was_full;
    in_valid = v; in_pcm = d; rd_en = rd; flush = fl; ovf_clear = oc;
    push     = v && enable;
    pop      = rd && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    @(posedge clk);
    #1;
    in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    if (fl) begin
      q.delete();
      if (oc) m_ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push && (!was_full || pop)) q.push_back(d);
      if (push && was_full && !pop) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
    end
    m_irq = (threshold != 0) && (q.size() >= int'(threshold));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
  endtask

`ifndef PDM_PCM_DCBLOCK_EN
  task automatic test_fill_drain();
    threshold = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      checks++; if (level !== 4'(i)) begin failures++; $display("FAIL fill_level: got %0d want %0d", level, i); end
      checks++; if (irq !== (i == 4)) begin failures++; $display("FAIL fill_irq: got %b want %b at push %0d", irq, (i == 4), i); end
    end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_data !== 16'(i)) begin failures++; $display("FAIL drain_data: got %h want %h", rd_data, 16'(i)); end
      drive(1'b0, 16'h0, 1'b1);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b want 1", empty); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL drain_rd_data: got %h want 0000", rd_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL drain_irq: got %b want 0", irq); end
    threshold = 4'd0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 1'b0);
      checks++; if (full !== (i >= 7)) begin failures++; $display("FAIL ovf_full: got %b want %b at push %0d", full, (i >= 7), i); end
      checks++; if (overflow !== (i == 8)) begin failures++; $display("FAIL ovf_flag: got %b want %b at push %0d", overflow, (i == 8), i); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 16'h0010 + 16'(i)) begin failures++; $display("FAIL ovf_drain: got %h want %h", rd_data, 16'h0010 + 16'(i)); end
      drive(1'b0, 16'h0, 1'b1);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty: got %b want 1", empty); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0);
    drive(1'b1, 16'h0BAD, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clear: got %b want 1", overflow); end
    checks++; if (rd_data !== 16'h0100) begin failures++; $display("FAIL ovf_oldest_kept: got %h want 0100", rd_data); end
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reclear: got %b want 0", overflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0200 + 16'(i), 1'b0);
    drive(1'b1, 16'h02AA, 1'b1);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL simul_full_level: got %0d want 8", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simul_full_ovf: got %b want 0", overflow); end
    checks++; if (rd_data !== 16'h0201) begin failures++; $display("FAIL simul_full_head: got %h want 0201", rd_data); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== m_head()) begin failures++; $display("FAIL simul_drain: got %h want %h", rd_data, m_head()); end
      if (i == 7) begin
        checks++; if (rd_data !== 16'h02AA) begin failures++; $display("FAIL simul_last: got %h want 02AA", rd_data); end
      end
      drive(1'b0, 16'h0, 1'b1);
    end
    drive(1'b1, 16'h0333, 1'b1);
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL simul_empty_level: got %0d want 1", level); end
    checks++; if (rd_data !== 16'h0333) begin failures++; $display("FAIL simul_empty_data: got %h want 0333", rd_data); end
    // Mixed traffic long enough to wrap both pointers.
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)));
      checks++; if (level !== 4'(q.size())) begin failures++; $display("FAIL wrap_level: got %0d want %0d", level, q.size()); end
      checks++; if (rd_data !== m_head()) begin failures++; $display("FAIL wrap_data: got %h want %h", rd_data, m_head()); end
    end
    while (q.size() > 0) begin
      checks++; if (rd_data !== m_head()) begin failures++; $display("FAIL wrap_drain: got %h want %h", rd_data, m_head()); end
      drive(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_flush();
    bit ovf_before;
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h0400 + 16'(i), 1'b0);
    ovf_before = overflow;
    drive(1'b1, 16'h0444, 1'b1, 1'b1);
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL flush_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty: got %b want 1", empty); end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL flush_ovf: got %b want %b (before %b)", overflow, m_ovf, ovf_before); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL flush_discard: got %h want 0000", rd_data); end
  endtask

  task automatic test_async_reset();
    threshold = 4'd2;
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0500 + 16'(i), 1'b0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL arst_pre_irq: got %b want 1", irq); end
    #2;
    rd_en = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL arst_level: got %0d want 0", level); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq: got %b want 0", irq); end
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_rd_hold: got empty=%b want 1", empty); end
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    q.delete(); m_ovf = 1'b0; m_irq = 1'b0;
    @(posedge clk); #1;
    checks++; if (level !== 4'd0 || rd_data !== 16'h0) begin failures++; $display("FAIL arst_after: got level=%0d data=%h want 0/0000", level, rd_data); end
    threshold = 4'd0;
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h0600 + 16'(i), 1'b0);
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL enable_ignored: got level %0d want 0", level); end
    enable = 1'b1;
    drive(1'b1, 16'h0666, 1'b0);
    checks++; if (level !== 4'd1 || rd_data !== 16'h0666) begin failures++; $display("FAIL enable_push: got level=%0d data=%h want 1/0666", level, rd_data); end
    drive(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) threshold = 4'($urandom_range(0, 11));
      enable = ($urandom_range(0, 15) != 0);
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 20) == 0));
      checks++;
      if (level !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          rd_data !== m_head() || irq !== m_irq || overflow !== m_ovf) begin
        failures++;
        $display("FAIL random_cycle%0d: got lvl=%0d e=%b f=%b d=%h irq=%b ovf=%b want lvl=%0d d=%h irq=%b ovf=%b",
                 i, level, empty, full, rd_data, irq, overflow, q.size(), m_head(), m_irq, m_ovf);
      end
    end
    enable = 1'b1;
    threshold = 4'd0;
  endtask
`else
  longint m_acc = 0;

  function automatic logic [15:0] dc_model(input longint x);
    longint est, diff;
    est   = m_acc >>> 6;
    diff  = x - est;
    m_acc = m_acc + diff;
    if (diff > 32767)  return 16'h7FFF;
    if (diff < -32768) return 16'h8000;
    return 16'(diff);
  endfunction

  task automatic dc_sample(input logic [15:0] x, input string name);
    logic [15:0] y;
    y = dc_model(longint'($signed(x)));
    in_pcm = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL %s_latency: got level %0d want 0", name, level); end
    @(posedge clk); #1;
    checks++; if (level !== 4'd1 || rd_data !== y) begin failures++; $display("FAIL %s_data: got level=%0d data=%h want 1/%h", name, level, rd_data, y); end
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_dc_block();
    pcm_t y;
    for (int i = 0; i < 2000; i++) dc_sample(16'h1000, "dc_const");
    y = pcm_t'(dc_model(64'sh1000));
    m_acc = m_acc - (64'sh1000 - (m_acc >>> 6)); // undo the peek
    checks++; if (y > 2 || y < -2) begin failures++; $display("FAIL dc_decay: got %0d want |y|<=2", y); end
    for (int i = 0; i < 2000; i++) dc_sample(16'h9000, "dc_neg");
    checks++; if ((m_acc >>> 6) != -28672) begin failures++; $display("FAIL dc_settle_model: got %0d want -28672", m_acc >>> 6); end
    dc_sample(16'h7FFF, "dc_step");
    in_pcm = 16'h7FFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (rd_data !== 16'h7FFF) begin failures++; $display("FAIL dc_saturate: got %h want 7FFF", rd_data); end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
`ifndef PDM_PCM_DCBLOCK_EN
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_enable();
    test_random();
`else
    test_dc_block();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pdm_pcm_fifo
